// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer
// ----------------------------------------------------------------------------
// Instruction-fetch controller. It commands an external program counter, issues
// instruction-memory reads at the current PC and buffers one fetched word. That
// word goes to decode over a valid/ready handshake. Jump redirects and a halt
// instruction are also handled here.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   : a wait counter bounds each FETCH at TIMEOUT_CYCLES cycles
//               without mem_ack. On expiry, fetch_error pulses for one cycle,
//               mem_req drops for that cycle and the read is reissued at the
//               same PC.
//   undefined : no counter; fetch_error is constant 0; FETCH waits forever.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   enable         in   fetching permitted when high
//   pc_value       in   current PC from the program counter [ADDR_W]
//   pc_opcode      out  PC command: 0 RESET, 1 PRESET, 2 INCR, 3 HALT
//   pc_load_value  out  preset value, meaningful when pc_opcode=PRESET
//   mem_req        out  read request (level)
//   mem_addr       out  read address (always the current PC)
//   mem_ack        in   read data valid, honoured only while mem_req=1
//   mem_rdata      in   read data [DATA_W]
//   instr_valid    out  buffered instruction available
//   instr_data     out  buffered instruction
//   instr_pc       out  address the buffered instruction was fetched from
//   instr_ready    in   decode accepts the instruction
//   redirect       in   single-cycle jump request
//   redirect_pc    in   jump target
//   halted         out  sequencer is in the HALTED state
//   fetch_error    out  fetch timeout pulse (0 without FETCH_TIMEOUT_EN)
//
// pc_opcode, pc_load_value, mem_req and fetch_error respond in the same cycle
// as mem_ack and redirect. They are therefore decoded combinationally from the
// registered state and these inputs. All other outputs come straight from
// flops.
// ============================================================================
module fetch_sequencer #(
    parameter int unsigned             ADDR_W         = 16,
    parameter int unsigned             DATA_W         = 16,
    parameter logic [DATA_W-1:0]       HALT_WORD      = 16'hFFFF,
    parameter int unsigned             TIMEOUT_CYCLES = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] pc_value,
    output logic [1:0]        pc_opcode,
    output logic [ADDR_W-1:0] pc_load_value,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic              fetch_error
);

    // PC command encodings
    localparam logic [1:0] OP_RESET  = 2'd0;
    localparam logic [1:0] OP_PRESET = 2'd1;
    localparam logic [1:0] OP_INCR   = 2'd2;
    localparam logic [1:0] OP_HALT   = 2'd3;

    // FSM states
    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_FETCH   = 3'd2;
    localparam logic [2:0] ST_DELIVER = 3'd3;
    localparam logic [2:0] ST_HALTED  = 3'd4;

    logic [2:0]        state_q,       state_d;
    logic [DATA_W-1:0] instr_data_q,  instr_data_d;
    logic [ADDR_W-1:0] instr_pc_q,    instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              halted_q,      halted_d;

    logic [1:0]        pc_opcode_s;
    logic [ADDR_W-1:0] pc_load_value_s;
    logic              mem_req_s;
    logic              redirect_take_s;
    logic              timeout_hit_s;

    // The PC must see exactly one RESET command, so a redirect in INIT is ignored.
    assign redirect_take_s = redirect && (state_q != ST_INIT);

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned       CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // The counter holds 0 outside FETCH. Because it only counts inside FETCH,
    // it is already cleared on every entry into FETCH.
    assign timeout_hit_s = (state_q == ST_FETCH) && (wait_cnt_q == TIMEOUT_VAL);

    // Wait counter next-state: count ack-less FETCH cycles; clear on expiry/redirect/exit
    always_comb begin
        wait_cnt_d = {CNT_W{1'b0}};
        if (!redirect_take_s && (state_q == ST_FETCH) && !timeout_hit_s && !mem_ack) begin
            wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_d = {CNT_W{1'b0}};
        end
    end

    // Wait counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= {CNT_W{1'b0}};
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A redirect in the expiry cycle takes priority and suppresses the pulse.
    assign fetch_error = timeout_hit_s && !redirect_take_s;
`else
    // TIMEOUT_CYCLES stays in the parameter list so both builds share one
    // interface. Here it only feeds a term that is constant 0.
    assign timeout_hit_s = 1'b0 & (TIMEOUT_CYCLES > 0);
    assign fetch_error   = 1'b0;
`endif

    // FSM next-state, PC command, memory request and instruction buffer capture
    always_comb begin
        state_d         = state_q;
        instr_data_d    = instr_data_q;
        instr_pc_d      = instr_pc_q;
        pc_opcode_s     = OP_HALT;
        pc_load_value_s = {ADDR_W{1'b0}};
        mem_req_s       = 1'b0;

        if (redirect_take_s) begin
            // Redirect has top priority. Any same-cycle mem_ack is dropped
            // because mem_req is held low. Leaving DELIVER discards the buffer.
            pc_opcode_s     = OP_PRESET;
            pc_load_value_s = redirect_pc;
            state_d         = enable ? ST_FETCH : ST_IDLE;
        end else begin
            case (state_q)
                ST_INIT: begin
                    pc_opcode_s = OP_RESET;
                    state_d     = ST_IDLE;
                end
                ST_IDLE: begin
                    if (enable) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (timeout_hit_s) begin
                        // Drop the request for one cycle, then retry at the same PC.
                        mem_req_s = 1'b0;
                        state_d   = ST_FETCH;
                    end else begin
                        mem_req_s = 1'b1;
                        // After enable falls, stay here until the ack arrives:
                        // memory must not see mem_req fall while unacknowledged.
                        if (mem_ack) begin
                            instr_data_d = mem_rdata;
                            instr_pc_d   = pc_value;
                            pc_opcode_s  = OP_INCR;
                            state_d      = ST_DELIVER;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DELIVER: begin
                    if (instr_ready) begin
                        if (instr_data_q == HALT_WORD) begin
                            state_d = ST_HALTED;
                        end else if (enable) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_DELIVER;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    // An unreachable encoding restarts through INIT so the PC is reset.
                    pc_opcode_s = OP_RESET;
                    state_d     = ST_INIT;
                end
            endcase
        end

        // These two flags are registered decodes of the next state. They stay
        // glitch-free and match state_q in every cycle.
        instr_valid_d = (state_d == ST_DELIVER);
        halted_d      = (state_d == ST_HALTED);
    end

    // State and instruction buffer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_INIT;
            instr_data_q  <= {DATA_W{1'b0}};
            instr_pc_q    <= {ADDR_W{1'b0}};
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_data_q  <= instr_data_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign pc_opcode     = pc_opcode_s;
    assign pc_load_value = pc_load_value_s;
    assign mem_req       = mem_req_s;
    assign mem_addr      = pc_value;
    assign instr_valid   = instr_valid_q;
    assign instr_data    = instr_data_q;
    assign instr_pc      = instr_pc_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer. The stimulus is a table of per-cycle vectors
// with hand-computed expected outputs, plus hand-written timeout and reset
// sequences. A small program-counter model turns pc_opcode/pc_load_value into
// the pc_value the DUT sees in the next cycle.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] pc_value;
    logic [1:0]  pc_opcode;
    logic [15:0] pc_load_value;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;
    logic        fetch_error;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        en;
        logic        ack;
        logic [15:0] rdata;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic [1:0]  op;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] data;
        logic [15:0] ipc;
        logic        hlt;
        logic [15:0] ld;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    fetch_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .pc_value      (pc_value),
        .pc_opcode     (pc_opcode),
        .pc_load_value (pc_load_value),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .halted        (halted),
        .fetch_error   (fetch_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic vec_t mk(input logic rst, input logic en, input logic ack,
                                input logic [15:0] rdata, input logic rdy,
                                input logic redir, input logic [15:0] rpc,
                                input logic [1:0] op, input logic req,
                                input logic [15:0] addr, input logic vld,
                                input logic [15:0] data, input logic [15:0] ipc,
                                input logic hlt, input logic [15:0] ld,
                                input logic err);
        vec_t v;
        v.rst = rst; v.en = en; v.ack = ack; v.rdata = rdata; v.rdy = rdy;
        v.redir = redir; v.rpc = rpc; v.op = op; v.req = req; v.addr = addr;
        v.vld = vld; v.data = data; v.ipc = ipc; v.hlt = hlt; v.ld = ld; v.err = err;
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge, check outputs, then clock
    // the edge and update the PC model from the command issued in that cycle.
    task automatic step(input vec_t v, input string name);
        logic [1:0]  op_s;
        logic [15:0] ld_s;
        @(negedge clock);
        reset       = v.rst;
        enable      = v.en;
        mem_ack     = v.ack;
        mem_rdata   = v.rdata;
        instr_ready = v.rdy;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        #1;
        checks++;
        if ({pc_opcode, mem_req, mem_addr, instr_valid, instr_data, instr_pc,
             halted, pc_load_value, fetch_error} !==
            {v.op, v.req, v.addr, v.vld, v.data, v.ipc, v.hlt, v.ld, v.err}) begin
            errors++;
            $display("FAIL %s: got op=%0d req=%b addr=%h vld=%b data=%h ipc=%h hlt=%b ld=%h err=%b; want op=%0d req=%b addr=%h vld=%b data=%h ipc=%h hlt=%b ld=%h err=%b",
                     name, pc_opcode, mem_req, mem_addr, instr_valid, instr_data,
                     instr_pc, halted, pc_load_value, fetch_error, v.op, v.req,
                     v.addr, v.vld, v.data, v.ipc, v.hlt, v.ld, v.err);
        end
        op_s = pc_opcode;
        ld_s = pc_load_value;
        @(posedge clock);
        #1;
        case (op_s)
            2'd0:    pc_value = 16'h0000;
            2'd1:    pc_value = ld_s;
            2'd2:    pc_value = pc_value + 16'h0001;
            default: pc_value = pc_value;
        endcase
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        pc_value    = 16'h0BAD;

        //                 rst  en   ack  rdata     rdy  rdr  rpc       op    req  addr      vld  data      ipc       hlt  ld        err
        tbl.push_back(mk(1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd0,1'b0,16'h0BAD,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0)); // 0 reset
        tbl.push_back(mk(1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0)); // 1
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0)); // 2 INIT
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0)); // 3 IDLE
        tbl.push_back(mk(1'b0,1'b1,1'b1,16'h1234,1'b0,1'b0,16'h0000, 2'd2,1'b1,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0)); // 4 FETCH ack
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'h0001,1'b1,16'h1234,16'h0000,1'b0,16'h0000,1'b0)); // 5 stall
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'h0001,1'b1,16'h1234,16'h0000,1'b0,16'h0000,1'b0)); // 6
        tbl.push_back(mk(1'b0,1'b1,1'b1,16'hBEEF,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'h0001,1'b1,16'h1234,16'h0000,1'b0,16'h0000,1'b0)); // 7 stray ack
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'h0001,1'b1,16'h1234,16'h0000,1'b0,16'h0000,1'b0)); // 8
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'h0001,1'b1,16'h1234,16'h0000,1'b0,16'h0000,1'b0)); // 9
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 2'd3,1'b0,16'h0001,1'b1,16'h1234,16'h0000,1'b0,16'h0000,1'b0)); // 10 accept
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b1,16'h0001,1'b0,16'h1234,16'h0000,1'b0,16'h0000,1'b0)); // 11 enable drop
        tbl.push_back(mk(1'b0,1'b0,1'b1,16'h5678,1'b0,1'b0,16'h0000, 2'd2,1'b1,16'h0001,1'b0,16'h1234,16'h0000,1'b0,16'h0000,1'b0)); // 12 ack
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b1,1'b0,16'h0000, 2'd3,1'b0,16'h0002,1'b1,16'h5678,16'h0001,1'b0,16'h0000,1'b0)); // 13 -> IDLE
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'h0002,1'b0,16'h5678,16'h0001,1'b0,16'h0000,1'b0)); // 14
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'h0002,1'b0,16'h5678,16'h0001,1'b0,16'h0000,1'b0)); // 15
        tbl.push_back(mk(1'b0,1'b1,1'b1,16'h9ABC,1'b0,1'b0,16'h0000, 2'd2,1'b1,16'h0002,1'b0,16'h5678,16'h0001,1'b0,16'h0000,1'b0)); // 16
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b1,1'b1,16'h0040, 2'd1,1'b0,16'h0003,1'b1,16'h9ABC,16'h0002,1'b0,16'h0040,1'b0)); // 17 redirect in DELIVER
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b1,16'h0040,1'b0,16'h9ABC,16'h0002,1'b0,16'h0000,1'b0)); // 18
        tbl.push_back(mk(1'b0,1'b1,1'b1,16'h1111,1'b0,1'b1,16'h0080, 2'd1,1'b0,16'h0040,1'b0,16'h9ABC,16'h0002,1'b0,16'h0080,1'b0)); // 19 ack+redirect
        tbl.push_back(mk(1'b0,1'b1,1'b1,16'hFFFF,1'b0,1'b0,16'h0000, 2'd2,1'b1,16'h0080,1'b0,16'h9ABC,16'h0002,1'b0,16'h0000,1'b0)); // 20 halt word
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 2'd3,1'b0,16'h0081,1'b1,16'hFFFF,16'h0080,1'b0,16'h0000,1'b0)); // 21
        tbl.push_back(mk(1'b0,1'b1,1'b1,16'h0000,1'b1,1'b0,16'h0000, 2'd3,1'b0,16'h0081,1'b0,16'hFFFF,16'h0080,1'b1,16'h0000,1'b0)); // 22 HALTED
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'h0081,1'b0,16'hFFFF,16'h0080,1'b1,16'h0000,1'b0)); // 23
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0010, 2'd1,1'b0,16'h0081,1'b0,16'hFFFF,16'h0080,1'b1,16'h0010,1'b0)); // 24 leave HALTED
        tbl.push_back(mk(1'b0,1'b1,1'b1,16'h2222,1'b0,1'b0,16'h0000, 2'd2,1'b1,16'h0010,1'b0,16'hFFFF,16'h0080,1'b0,16'h0000,1'b0)); // 25
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,16'hFFFF, 2'd1,1'b0,16'h0011,1'b1,16'h2222,16'h0010,1'b0,16'hFFFF,1'b0)); // 26 redirect -> IDLE
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'hFFFF,1'b0,16'h2222,16'h0010,1'b0,16'h0000,1'b0)); // 27
        tbl.push_back(mk(1'b0,1'b1,1'b1,16'h3333,1'b0,1'b0,16'h0000, 2'd2,1'b1,16'hFFFF,1'b0,16'h2222,16'h0010,1'b0,16'h0000,1'b0)); // 28 wrap
        tbl.push_back(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'h0000,1'b1,16'h3333,16'hFFFF,1'b0,16'h0000,1'b0)); // 29
        tbl.push_back(mk(1'b1,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0)); // 30 async reset
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,1'b1,16'h0555, 2'd0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0)); // 31 redirect in INIT
        tbl.push_back(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0)); // 32 IDLE

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Long FETCH with no ack: a timeout pulse every 5th cycle, or else a steady request.
        step(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0), "wait_idle");
        for (int k = 0; k < 12; k++) begin
            logic err_e;
`ifdef FETCH_TIMEOUT_EN
            err_e = ((k % 5) == 4);
`else
            err_e = 1'b0;
`endif
            step(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,~err_e,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000,err_e),
                 $sformatf("wait%0d", k));
        end
        step(mk(1'b0,1'b1,1'b1,16'h4444,1'b0,1'b0,16'h0000, 2'd2,1'b1,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0), "late_ack");
        step(mk(1'b0,1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000, 2'd3,1'b0,16'h0001,1'b1,16'h4444,16'h0000,1'b0,16'h0000,1'b0), "late_deliver");
        step(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b1,16'h0001,1'b0,16'h4444,16'h0000,1'b0,16'h0000,1'b0), "wait_b0");
        step(mk(1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd3,1'b1,16'h0001,1'b0,16'h4444,16'h0000,1'b0,16'h0000,1'b0), "wait_b1");
        // Reset in the middle of a wait: outputs must clear before any edge.
        step(mk(1'b1,1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd0,1'b0,16'h0001,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0), "reset_mid_wait");
        step(mk(1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000, 2'd0,1'b0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,16'h0000,1'b0), "reinit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
